// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared definitions for the ram_arbiter slice.
//   state_t      - access sequencer states (IDLE, SETUP, STROBE, HOLD)
//   PORT0/PORT1  - requester identifiers used for grant bookkeeping
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-request round-robin grant.
//   clk, rst    - clock, synchronous active-high reset
//   req0, req1  - request lines
//   accept      - the current grant was taken this cycle; advances the pointer
//   gnt0, gnt1  - combinational one-hot (or zero) grant
// When both request, the port not served last wins; reset favours port 0.
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

  logic last;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (last == PORT1) gnt0 = 1'b1;
      else               gnt1 = 1'b1;
    end else if (req0) begin
      gnt0 = 1'b1;
    end else if (req1) begin
      gnt1 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT1;
    end else if (accept && (gnt0 || gnt1)) begin
      last <= gnt1 ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and access sequencer for a
// single-port asynchronous RAM.
//   clk, rst                       - clock, synchronous active-high reset
//   reqN_valid/ready/we/addr/wdata - command handshake for port N (0, 1)
//   rspN_valid/rdata               - one-cycle completion pulse and read data
//   ram_address/data_in/data_out   - RAM address and data buses
//   ram_cs/we/oe                   - RAM strobes
// Optional (macro RAM_ARBITER_STATS_EN): stat_grants0, stat_grants1,
// stat_conflicts - saturating 16-bit event counters.
// Sequence per access: IDLE -> SETUP -> STROBE x ACCESS_CYCLES -> HOLD.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
`ifdef RAM_ARBITER_STATS_EN
  ,
  output logic [15:0]           stat_grants0,
  output logic [15:0]           stat_grants1,
  output logic [15:0]           stat_conflicts
`endif
);

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       cmd_we;
  logic       cmd_port;
  logic       idle;
  logic       gnt0, gnt1;
  logic       hs;
  logic       last_strobe;

  // Ready is held low while rst is high so no command is taken during reset.
  assign idle        = (state == IDLE) && !rst;
  assign req0_ready  = idle && gnt0;
  assign req1_ready  = idle && gnt1;
  assign hs          = req0_ready || req1_ready;
  assign last_strobe = (state == STROBE) && (cnt == '0);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .accept (hs),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  always_comb begin
    state_next = state;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_oe     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state)
      IDLE:   if (hs) state_next = SETUP;
      SETUP:  state_next = STROBE;
      STROBE: begin
        ram_cs = 1'b1;
        ram_we = cmd_we;
        ram_oe = !cmd_we;
        if (cnt == '0) state_next = HOLD;
      end
      HOLD: begin
        rsp0_valid = (cmd_port == PORT0);
        rsp1_valid = (cmd_port == PORT1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_we      <= 1'b0;
      cmd_port    <= PORT0;
      ram_address <= '0;
      ram_data_in <= '0;
      rsp0_rdata  <= '0;
      rsp1_rdata  <= '0;
    end else begin
      state <= state_next;
      // The latched command drives the RAM buses directly, so they only move
      // on a new handshake and stay put from SETUP through HOLD and IDLE.
      if (hs) begin
        cmd_we      <= req1_ready ? req1_we : req0_we;
        cmd_port    <= req1_ready ? PORT1 : PORT0;
        ram_address <= req1_ready ? req1_addr : req0_addr;
        ram_data_in <= req1_ready ? req1_wdata : req0_wdata;
      end
      if (state == SETUP) begin
        cnt <= 4'(ACCESS_CYCLES - 1);
      end else if ((state == STROBE) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      if (last_strobe) begin
        if (cmd_port == PORT0) rsp0_rdata <= cmd_we ? '0 : ram_data_out;
        else                   rsp1_rdata <= cmd_we ? '0 : ram_data_out;
      end
    end
  end

`ifdef RAM_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants0   <= '0;
      stat_grants1   <= '0;
      stat_conflicts <= '0;
    end else begin
      if (req0_ready && (stat_grants0 != '1)) stat_grants0 <= stat_grants0 + 16'd1;
      if (req1_ready && (stat_grants1 != '1)) stat_grants1 <= stat_grants1 + 16'd1;
      if (hs && req0_valid && req1_valid && (stat_conflicts != '1))
        stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule
